// File: rtl/uart_reg_bridge_pkg.sv
// Shared types and byte codes for the UART register bridge.
// The GET_CSUM state exists only when UART_REG_BRIDGE_CHECKSUM_EN is defined.
package uart_reg_bridge_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_ADDR,
    S_GET_DATA,
`ifdef UART_REG_BRIDGE_CHECKSUM_EN
    S_GET_CSUM,
`endif
    S_EXEC,
    S_WAIT_RD,
    S_RESP
  } state_e;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK  = 8'h06;
  localparam logic [7:0] RSP_NAK  = 8'h15;

endpackage

// File: rtl/uart_bridge_timeout.sv
// Inter-byte timeout: reloads on clear_i, counts down while en_i, and flags
// expiry on the TIMEOUT_CYCLES-th consecutive enabled cycle.
module uart_bridge_timeout #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: reload, decrement toward zero, or hold.
  always_comb begin
    if (clear_i) begin
      cnt_d = LOAD_VAL;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/uart_reg_bridge.sv
// UART command responder: parses read/write frames from the RX FIFO, drives a
// register bus and pushes ACK/NAK/read data. Optional: UART_REG_BRIDGE_CHECKSUM_EN.
module uart_reg_bridge
  import uart_reg_bridge_pkg::*;
#(
  parameter int ADDR_W         = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_data_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_data_ready,
  input  logic              rx_framing_err,
  output logic              rx_framing_err_clr,
  input  logic              tx_data_ready,
  output logic              tx_data_valid,
  output logic [7:0]        tx_data,
  output logic              reg_wr_en,
  output logic              reg_rd_en,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  input  logic [7:0]        reg_rdata,
  output logic [7:0]        err_count
);

`ifdef UART_REG_BRIDGE_CHECKSUM_EN
  localparam state_e AFTER_PAYLOAD = S_GET_CSUM;
`else
  localparam state_e AFTER_PAYLOAD = S_EXEC;
`endif

  state_e     state_q, state_d;
  logic       is_wr_q, is_wr_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] resp_q, resp_d;
  logic       nak_q, nak_d;
  logic [7:0] err_q, err_d;
  logic       gap_q;
  logic       wait_s, accept_s, abort_s, addr_bad_s, err_evt_s;
  logic       tmo_expired_s;

`ifdef UART_REG_BRIDGE_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
  logic       csum_ok_q, csum_ok_d;
  assign wait_s     = (state_q == S_GET_ADDR) || (state_q == S_GET_DATA) || (state_q == S_GET_CSUM);
  assign addr_bad_s = ((addr_q >> ADDR_W) != 8'h00) || !csum_ok_q;
`else
  assign wait_s     = (state_q == S_GET_ADDR) || (state_q == S_GET_DATA);
  assign addr_bad_s = (addr_q >> ADDR_W) != 8'h00;
`endif

  // gap_q blanks ready for the cycle after a pop, since FIFO empty status lags.
  assign accept_s      = ((state_q == S_IDLE) || wait_s) && rx_data_valid && !gap_q && !rx_framing_err;
  assign rx_data_ready = accept_s;
  assign abort_s       = rx_framing_err && (state_q != S_RESP);
  assign err_d         = (err_evt_s && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;

  uart_bridge_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (!wait_s || accept_s),
    .en_i     (wait_s && !accept_s),
    .expired_o(tmo_expired_s)
  );

  // Frame FSM: next state, datapath loads and one-cycle strobes.
  always_comb begin
    state_d            = state_q;
    is_wr_d            = is_wr_q;
    addr_d             = addr_q;
    wdata_d            = wdata_q;
    resp_d             = resp_q;
    nak_d              = nak_q;
    reg_wr_en          = 1'b0;
    reg_rd_en          = 1'b0;
    tx_data_valid      = 1'b0;
    rx_framing_err_clr = 1'b0;
    err_evt_s          = 1'b0;
`ifdef UART_REG_BRIDGE_CHECKSUM_EN
    csum_ok_d          = csum_ok_q;
`endif
    if (abort_s) begin
      state_d            = S_IDLE;
      rx_framing_err_clr = 1'b1;
      err_evt_s          = 1'b1;
    end else if (tmo_expired_s) begin
      state_d   = S_IDLE;
      err_evt_s = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_s && ((rx_data == OP_WRITE) || (rx_data == OP_READ))) begin
            is_wr_d = (rx_data == OP_WRITE);
            state_d = S_GET_ADDR;
          end else if (accept_s) begin
            resp_d  = RSP_NAK;
            nak_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_GET_ADDR: begin
          if (accept_s) begin
            addr_d  = rx_data;
            state_d = is_wr_q ? S_GET_DATA : AFTER_PAYLOAD;
          end else begin
            state_d = S_GET_ADDR;
          end
        end
        S_GET_DATA: begin
          if (accept_s) begin
            wdata_d = rx_data;
            state_d = AFTER_PAYLOAD;
          end else begin
            state_d = S_GET_DATA;
          end
        end
`ifdef UART_REG_BRIDGE_CHECKSUM_EN
        S_GET_CSUM: begin
          if (accept_s) begin
            csum_ok_d = (rx_data == csum_q);
            state_d   = S_EXEC;
          end else begin
            state_d = S_GET_CSUM;
          end
        end
`endif
        S_EXEC: begin
          if (addr_bad_s) begin
            resp_d  = RSP_NAK;
            nak_d   = 1'b1;
            state_d = S_RESP;
          end else if (is_wr_q) begin
            reg_wr_en = 1'b1;
            resp_d    = RSP_ACK;
            nak_d     = 1'b0;
            state_d   = S_RESP;
          end else begin
            reg_rd_en = 1'b1;
            state_d   = S_WAIT_RD;
          end
        end
        S_WAIT_RD: begin
          resp_d  = reg_rdata;
          nak_d   = 1'b0;
          state_d = S_RESP;
        end
        S_RESP: begin
          if (tx_data_ready) begin
            tx_data_valid = 1'b1;
            err_evt_s     = nak_q;
            state_d       = S_IDLE;
          end else begin
            state_d = S_RESP;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      is_wr_q <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      resp_q  <= 8'h00;
      nak_q   <= 1'b0;
      err_q   <= 8'h00;
      gap_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      is_wr_q <= is_wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      resp_q  <= resp_d;
      nak_q   <= nak_d;
      err_q   <= err_d;
      gap_q   <= accept_s;
    end
  end

`ifdef UART_REG_BRIDGE_CHECKSUM_EN
  // Running XOR of the frame, restarted by the opcode byte.
  always_comb begin
    if (accept_s && (state_q == S_IDLE)) begin
      csum_d = rx_data;
    end else if (accept_s) begin
      csum_d = csum_q ^ rx_data;
    end else begin
      csum_d = csum_q;
    end
  end

  // Checksum registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      csum_q    <= 8'h00;
      csum_ok_q <= 1'b0;
    end else begin
      csum_q    <= csum_d;
      csum_ok_q <= csum_ok_d;
    end
  end
`endif

  assign tx_data   = resp_q;
  assign reg_addr  = addr_q[ADDR_W-1:0];
  assign reg_wdata = wdata_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Bench for uart_reg_bridge (ADDR_W=4, TIMEOUT_CYCLES=50); define
// UART_REG_BRIDGE_CHECKSUM_EN to exercise checksum-trailed frames.
module tb_uart_reg_bridge;

  localparam int AW  = 4;
  localparam int TMO = 50;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rx_data_valid;
  logic [7:0]    rx_data;
  logic          rx_data_ready;
  logic          rx_framing_err;
  logic          rx_framing_err_clr;
  logic          tx_data_ready;
  logic          tx_data_valid;
  logic [7:0]    tx_data;
  logic          reg_wr_en;
  logic          reg_rd_en;
  logic [AW-1:0] reg_addr;
  logic [7:0]    reg_wdata;
  logic [7:0]    reg_rdata;
  logic [7:0]    err_count;

  always #5 clk = ~clk;

  uart_reg_bridge #(.ADDR_W(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .rx_data_valid     (rx_data_valid),
    .rx_data           (rx_data),
    .rx_data_ready     (rx_data_ready),
    .rx_framing_err    (rx_framing_err),
    .rx_framing_err_clr(rx_framing_err_clr),
    .tx_data_ready     (tx_data_ready),
    .tx_data_valid     (tx_data_valid),
    .tx_data           (tx_data),
    .reg_wr_en         (reg_wr_en),
    .reg_rd_en         (reg_rd_en),
    .reg_addr          (reg_addr),
    .reg_wdata         (reg_wdata),
    .reg_rdata         (reg_rdata),
    .err_count         (err_count)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int clr_cnt = 0;
  int viol = 0;
  int acc_cyc = 0;
  int mdl_err = 0;
  logic          prev_ready = 1'b0;
  logic [AW-1:0] last_wr_addr = '0;
  logic [7:0]    last_wr_data = 8'h00;
  logic [7:0]    tx_q[$];
  int            tx_cyc_q[$];
  logic [7:0]    dev [16] = '{default: 8'h00};
  logic [7:0]    mdl [16] = '{default: 8'h00};

  // Register block: reads return data the cycle after the strobe, junk otherwise.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reg_wr_en) dev[reg_addr] <= reg_wdata;
    reg_rdata <= reg_rd_en ? dev[reg_addr] : 8'hEE;
  end

  // Bus monitor.
  always @(negedge clk) begin
    if (rst_n) begin
      if (reg_wr_en) begin
        wr_cnt       <= wr_cnt + 1;
        last_wr_addr <= reg_addr;
        last_wr_data <= reg_wdata;
      end
      if (reg_rd_en) rd_cnt <= rd_cnt + 1;
      if (rx_framing_err_clr) clr_cnt <= clr_cnt + 1;
      if (tx_data_valid) begin
        tx_q.push_back(tx_data);
        tx_cyc_q.push_back(cyc);
      end
      if ((tx_data_valid && !tx_data_ready) || (reg_wr_en && reg_rd_en) || (rx_data_ready && prev_ready))
        viol <= viol + 1;
    end
    prev_ready <= rx_data_ready;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data       = b;
    rx_data_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!rx_data_ready && n < 200);
    acc_cyc = cyc;
    chk("byte_accept", {31'd0, rx_data_ready}, 32'd1);
    @(posedge clk);
    #1;
    rx_data_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [7:0] addr,
                            input logic [7:0] data, input logic [7:0] mask);
    logic [7:0] cs;
    cs = op;
    send_byte(op);
    if (op == 8'h57 || op == 8'h52) begin
      send_byte(addr);
      cs = cs ^ addr;
      if (op == 8'h57) begin
        send_byte(data);
        cs = cs ^ data;
      end
`ifdef UART_REG_BRIDGE_CHECKSUM_EN
      send_byte(cs ^ mask);
`endif
    end
  endtask

  task automatic bump_err();
    mdl_err = (mdl_err < 255) ? mdl_err + 1 : 255;
  endtask

  // Send a frame, then check response byte, latency, strobes and error count.
  task automatic run_frame(input logic [7:0] op, input logic [7:0] addr,
                           input logic [7:0] data, input logic [7:0] mask);
    logic [7:0] exp_rsp;
    int wr0, rd0, exp_wr, exp_rd, exp_lat, n;
    bit valid_op, ok;
    wr0      = wr_cnt;
    rd0      = rd_cnt;
    valid_op = (op == 8'h57) || (op == 8'h52);
    send_frame(op, addr, data, mask);
    ok      = valid_op && (int'(addr) < (1 << AW)) && (mask == 8'h00);
    exp_wr  = 0;
    exp_rd  = 0;
    exp_rsp = 8'h15;
    exp_lat = 2;
    if (ok && op == 8'h57) begin
      exp_wr  = 1;
      exp_rsp = 8'h06;
      mdl[addr[AW-1:0]] = data;
    end else if (ok) begin
      exp_rd  = 1;
      exp_rsp = mdl[addr[AW-1:0]];
      exp_lat = 3;
    end else begin
      bump_err();
    end
    n = 0;
    while (tx_q.size() == 0 && n < 30) begin
      tick(1);
      n++;
    end
    chk("resp_present", tx_q.size(), 1);
    if (tx_q.size() > 0) begin
      chk("resp_byte", {24'd0, tx_q[0]}, {24'd0, exp_rsp});
      if (valid_op) chk("resp_latency", tx_cyc_q[0] - acc_cyc, exp_lat);
      void'(tx_q.pop_front());
      void'(tx_cyc_q.pop_front());
    end
    tick(3);
    chk("wr_strobes", wr_cnt - wr0, exp_wr);
    chk("rd_strobes", rd_cnt - rd0, exp_rd);
    if (exp_wr != 0) begin
      chk("wr_addr", {28'd0, last_wr_addr}, {24'd0, addr} & 32'hF);
      chk("wr_data", {24'd0, last_wr_data}, {24'd0, data});
    end
    chk("err_count", {24'd0, err_count}, mdl_err);
    chk("no_extra_tx", tx_q.size(), 0);
  endtask

  logic [7:0] op_v, addr_v, data_v, mask_v;
  int r, n0, c0;

  initial begin
    rst_n          = 1'b0;
    rx_data_valid  = 1'b0;
    rx_data        = 8'h00;
    rx_framing_err = 1'b0;
    tx_data_ready  = 1'b1;
    tick(3);
    chk("rst_strobes", {27'd0, rx_data_ready, tx_data_valid, reg_wr_en, reg_rd_en, rx_framing_err_clr}, 32'd0);
    chk("rst_data", {4'd0, tx_data, reg_addr, reg_wdata, err_count}, 32'd0);
    rst_n = 1'b1;
    tick(2);

    run_frame(8'h57, 8'h03, 8'hA5, 8'h00);
    run_frame(8'h52, 8'h03, 8'h00, 8'h00);
    run_frame(8'h57, 8'h03, 8'h3C, 8'h00);
    run_frame(8'h52, 8'h03, 8'h00, 8'h00);
    run_frame(8'h41, 8'h00, 8'h00, 8'h00);
    run_frame(8'h57, 8'h1F, 8'h77, 8'h00);
    chk("err_after_two_naks", {24'd0, err_count}, 32'd2);

    // Timeout mid-frame.
    send_byte(8'h57);
    send_byte(8'h02);
    tick(45);
    chk("tmo_not_yet", {24'd0, err_count}, mdl_err);
    tick(10);
    bump_err();
    chk("tmo_err", {24'd0, err_count}, mdl_err);
    chk("tmo_no_tx", tx_q.size(), 0);
    run_frame(8'h52, 8'h02, 8'h00, 8'h00);

    // Response held by TX backpressure.
    tx_data_ready = 1'b0;
    send_frame(8'h57, 8'h05, 8'h5A, 8'h00);
    mdl[5] = 8'h5A;
    tick(20);
    chk("bp_no_push", tx_q.size(), 0);
    tx_data_ready = 1'b1;
    tick(4);
    chk("bp_one_push", tx_q.size(), 1);
    if (tx_q.size() > 0) begin
      chk("bp_byte", {24'd0, tx_q[0]}, 32'h06);
      void'(tx_q.pop_front());
      void'(tx_cyc_q.pop_front());
    end
    run_frame(8'h52, 8'h05, 8'h00, 8'h00);

    // Framing error after the opcode.
    c0 = clr_cnt;
    send_byte(8'h57);
    rx_framing_err = 1'b1;
    n0 = 0;
    do begin
      @(negedge clk);
      n0++;
    end while (!rx_framing_err_clr && n0 < 20);
    @(posedge clk);
    #1;
    rx_framing_err = 1'b0;
    bump_err();
    tick(3);
    chk("frm_clr_pulse", clr_cnt - c0, 1);
    chk("frm_err", {24'd0, err_count}, mdl_err);
    chk("frm_no_tx", tx_q.size(), 0);
    run_frame(8'h52, 8'h03, 8'h00, 8'h00);

    // Reset in the middle of a write frame.
    send_byte(8'h57);
    send_byte(8'h04);
    rst_n = 1'b0;
    tick(1);
    chk("midrst_strobes", {27'd0, rx_data_ready, tx_data_valid, reg_wr_en, reg_rd_en, rx_framing_err_clr}, 32'd0);
    chk("midrst_data", {4'd0, tx_data, reg_addr, reg_wdata, err_count}, 32'd0);
    rst_n   = 1'b1;
    mdl_err = 0;
    tick(3);
    chk("midrst_no_tx", tx_q.size(), 0);
    run_frame(8'h52, 8'h03, 8'h00, 8'h00);

`ifdef UART_REG_BRIDGE_CHECKSUM_EN
    run_frame(8'h57, 8'h01, 8'h22, 8'h00);
    run_frame(8'h57, 8'h01, 8'h22, 8'h74);
    run_frame(8'h52, 8'h01, 8'h00, 8'h00);
`endif

    for (int i = 0; i < 30; i++) begin
      r      = $urandom_range(0, 9);
      op_v   = (r < 4) ? 8'h57 : (r < 8) ? 8'h52 : 8'($urandom_range(0, 255));
      addr_v = ($urandom_range(0, 6) == 0) ? 8'($urandom_range(16, 255)) : 8'($urandom_range(0, 15));
      data_v = 8'($urandom_range(0, 255));
      mask_v = 8'h00;
`ifdef UART_REG_BRIDGE_CHECKSUM_EN
      if ($urandom_range(0, 5) == 0) mask_v = 8'($urandom_range(1, 255));
`endif
      run_frame(op_v, addr_v, data_v, mask_v);
    end

    chk("protocol_violations", viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

endmodule
